fib_seq_gen: RTL and testbench

Parametrised sequential Fibonacci/Lucas term generator. It replaces the fixed 64-entry Fibonacci lookup table driven by a free-running address counter. Terms are computed iteratively from two programmable seeds and streamed over a valid/ready interface with index, last-term and overflow reporting. It sits as a source block feeding downstream checkers or displays in the lab datapath.

---
 rtl/fib_seq_gen.sv | 118 +++++++++++
 tb/tb_fib_seq_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_gen.sv
// Streams Fibonacci-style terms computed from two programmable seeds over a valid/ready port,
// with per-term index, last-term flag and sticky overflow reporting.
module fib_seq_gen #(
    parameter int WIDTH       = 24,
    parameter int IDX_W       = 6,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] num_terms,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | presenting term a, advancing on each handshake
    // FIN   | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] num_q, num_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             pend_q, pend_d;
    logic [WIDTH:0]   sum;
    logic             is_last;

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign is_last = (idx_q == (num_q - IDX_ONE)) || (STOP_ON_OVF && pend_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        num_d   = num_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_terms;
                    a_d     = seed0;
                    b_d     = seed1;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = (num_terms == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    // overflow is raised when the invalid term would be presented, not when it is computed
                    if (pend_q && (STOP_ON_OVF || !is_last)) begin
                        ovf_d = 1'b1;
                    end
                    if (is_last) begin
                        state_d = S_FIN;
                    end else begin
                        a_d    = b_q;
                        b_d    = sum[WIDTH-1:0];
                        pend_d = sum[WIDTH];
                        idx_d  = idx_q + IDX_ONE;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == S_RUN);
    assign out_data  = a_q;
    assign out_idx   = idx_q;
    assign out_last  = (state_q == S_RUN) && is_last;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_FIN);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: a 24-bit instance plus two 8-bit instances
// (stop-on-overflow and wrapping) driven with hand-computed sequences.
module tb_fib_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_start, a_ready, a_valid, a_last, a_busy, a_done, a_ovf;
    logic [5:0]  a_num, a_idx;
    logic [23:0] a_s0, a_s1, a_data;

    logic        e_start, e_ready;
    logic [5:0]  e_num;
    logic [7:0]  e_s0, e_s1;

    logic        s_valid, s_last, s_busy, s_done, s_ovf;
    logic [5:0]  s_idx;
    logic [7:0]  s_data;
    logic        w_valid, w_last, w_busy, w_done, w_ovf;
    logic [5:0]  w_idx;
    logic [7:0]  w_data;

    fib_seq_gen #(.WIDTH(24), .IDX_W(6), .STOP_ON_OVF(1'b1)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .num_terms(a_num),
        .seed0(a_s0), .seed1(a_s1), .out_ready(a_ready), .out_valid(a_valid),
        .out_data(a_data), .out_idx(a_idx), .out_last(a_last), .busy(a_busy),
        .done(a_done), .overflow(a_ovf));

    fib_seq_gen #(.WIDTH(8), .IDX_W(6), .STOP_ON_OVF(1'b1)) u_s (
        .clk(clk), .reset(reset), .start(e_start), .num_terms(e_num),
        .seed0(e_s0), .seed1(e_s1), .out_ready(e_ready), .out_valid(s_valid),
        .out_data(s_data), .out_idx(s_idx), .out_last(s_last), .busy(s_busy),
        .done(s_done), .overflow(s_ovf));

    fib_seq_gen #(.WIDTH(8), .IDX_W(6), .STOP_ON_OVF(1'b0)) u_w (
        .clk(clk), .reset(reset), .start(e_start), .num_terms(e_num),
        .seed0(e_s0), .seed1(e_s1), .out_ready(e_ready), .out_valid(w_valid),
        .out_data(w_data), .out_idx(w_idx), .out_last(w_last), .busy(w_busy),
        .done(w_done), .overflow(w_ovf));

    int tests = 0;
    int fails = 0;

    logic [23:0] cd[$];
    logic [5:0]  ci[$];
    logic        cl[$];
    int          c_done_k, c_viol, c_valid_cnt;
    logic        c_to, c_ovf, c_done2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on the 24-bit instance and records every accepted term.
    task automatic cap24(input logic [23:0] s0, input logic [23:0] s1, input logic [5:0] n,
                         input bit rnd, input bit disturb);
        logic [23:0] hd;
        logic [5:0]  hi;
        logic        hl;
        bit          stalled;
        cd.delete(); ci.delete(); cl.delete();
        hd = '0; hi = '0; hl = 1'b0; stalled = 0;
        c_done_k = -1; c_viol = 0; c_valid_cnt = 0; c_to = 1'b1; c_ovf = 1'bx;
        a_s0 = s0; a_s1 = s1; a_num = n; a_start = 1'b1;
        tick;
        if (disturb) begin
            a_s0 = 24'd99; a_s1 = 24'd98; a_num = 6'd2;
        end else begin
            a_start = 1'b0;
        end
        for (int k = 1; k <= 400; k++) begin
            if (stalled && (a_valid !== 1'b1 || a_data !== hd || a_idx !== hi || a_last !== hl))
                c_viol++;
            if (a_done === 1'b1) begin
                c_done_k = k; c_ovf = a_ovf; c_to = 1'b0;
                a_start = 1'b0; a_ready = 1'b0;
                break;
            end
            if (a_valid === 1'b1) c_valid_cnt++;
            a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_valid === 1'b1 && a_ready) begin
                cd.push_back(a_data); ci.push_back(a_idx); cl.push_back(a_last);
                stalled = 0;
            end else if (a_valid === 1'b1) begin
                stalled = 1; hd = a_data; hi = a_idx; hl = a_last;
            end
            tick;
        end
        a_start = 1'b0;
        tick;
        c_done2 = a_done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        tests++;
        if ({a_valid, a_data, a_idx, a_last, a_busy, a_done, a_ovf} !== '0) begin
            fails++; $display("FAIL reset_a: got %h expected 0", {a_valid, a_data, a_idx, a_last, a_busy, a_done, a_ovf});
        end
        tests++;
        if ({s_valid, s_data, s_idx, s_last, s_busy, s_done, s_ovf} !== '0) begin
            fails++; $display("FAIL reset_s: got %h expected 0", {s_valid, s_data, s_idx, s_last, s_busy, s_done, s_ovf});
        end
        tests++;
        if ({w_valid, w_data, w_idx, w_last, w_busy, w_done, w_ovf} !== '0) begin
            fails++; $display("FAIL reset_w: got %h expected 0", {w_valid, w_data, w_idx, w_last, w_busy, w_done, w_ovf});
        end
        reset = 1'b0;
        tick;
    endtask

    // Checks a captured 35-term Fibonacci run against an iterative reference.
    task automatic check_fib35(input string tag);
        logic [23:0] f0, f1, t;
        f0 = 24'd0; f1 = 24'd1;
        tests++;
        if (c_to !== 1'b0 || cd.size() != 35) begin
            fails++; $display("FAIL %s_count: got %0d terms (timeout=%b) expected 35", tag, cd.size(), c_to);
        end
        for (int i = 0; i < cd.size(); i++) begin
            tests++;
            if (cd[i] !== f0 || ci[i] !== 6'(i) || cl[i] !== (i == 34)) begin
                fails++; $display("FAIL %s_term%0d: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                                  tag, i, cd[i], ci[i], cl[i], f0, i, (i == 34));
            end
            t = f0 + f1; f0 = f1; f1 = t;
        end
        if (cd.size() == 35) begin
            tests++;
            if (cd[34] !== 24'd5702887) begin
                fails++; $display("FAIL %s_f34: got %0d expected 5702887", tag, cd[34]);
            end
        end
        tests++;
        if (c_ovf !== 1'b0) begin
            fails++; $display("FAIL %s_ovf: got %b expected 0", tag, c_ovf);
        end
        tests++;
        if (c_done2 !== 1'b0) begin
            fails++; $display("FAIL %s_done_width: got done=%b one cycle after done, expected 0", tag, c_done2);
        end
    endtask

    task automatic test_fib35;
        cap24(24'd0, 24'd1, 6'd35, 1'b0, 1'b0);
        check_fib35("fib35");
        tests++;
        if (c_done_k != 36) begin
            fails++; $display("FAIL fib35_done_cycle: got %0d expected 36", c_done_k);
        end
    endtask

    task automatic test_stall;
        cap24(24'd0, 24'd1, 6'd35, 1'b1, 1'b0);
        check_fib35("stall");
        tests++;
        if (c_viol != 0) begin
            fails++; $display("FAIL stall_hold: got %0d unstable stall cycles expected 0", c_viol);
        end
    endtask

    task automatic test_lucas;
        logic [23:0] exp_l [10];
        exp_l = '{24'd2, 24'd1, 24'd3, 24'd4, 24'd7, 24'd11, 24'd18, 24'd29, 24'd47, 24'd76};
        cap24(24'd2, 24'd1, 6'd10, 1'b0, 1'b0);
        tests++;
        if (c_to !== 1'b0 || cd.size() != 10) begin
            fails++; $display("FAIL lucas_count: got %0d expected 10", cd.size());
        end
        for (int i = 0; i < cd.size() && i < 10; i++) begin
            tests++;
            if (cd[i] !== exp_l[i] || ci[i] !== 6'(i) || cl[i] !== (i == 9)) begin
                fails++; $display("FAIL lucas_term%0d: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                                  i, cd[i], ci[i], cl[i], exp_l[i], i, (i == 9));
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [23:0] exp_g [4];
        exp_g = '{24'd5, 24'd8, 24'd13, 24'd21};
        cap24(24'd5, 24'd8, 6'd4, 1'b0, 1'b1);
        tests++;
        if (cd.size() != 4 || c_done_k != 5) begin
            fails++; $display("FAIL ignore_count: got %0d terms done at %0d expected 4 terms done at 5", cd.size(), c_done_k);
        end
        for (int i = 0; i < cd.size() && i < 4; i++) begin
            tests++;
            if (cd[i] !== exp_g[i]) begin
                fails++; $display("FAIL ignore_term%0d: got %0d expected %0d", i, cd[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_zero;
        cap24(24'd0, 24'd1, 6'd0, 1'b0, 1'b0);
        tests++;
        if (c_to !== 1'b0 || c_done_k != 1 || c_valid_cnt != 0) begin
            fails++; $display("FAIL zero_terms: got done at %0d valid cycles %0d expected done at 1 valid 0", c_done_k, c_valid_cnt);
        end
    endtask

    task automatic test_overflow8;
        logic [7:0] sd[$], wd[$];
        logic [5:0] si[$];
        logic       sl[$], wl[$];
        int         s_k, w_k;
        logic       s_o, w_o;
        s_k = -1; w_k = -1; s_o = 1'bx; w_o = 1'bx;
        e_s0 = 8'd0; e_s1 = 8'd1; e_num = 6'd20; e_start = 1'b1; e_ready = 1'b1;
        tick;
        e_start = 1'b0;
        for (int k = 1; k <= 100 && (s_k < 0 || w_k < 0); k++) begin
            if (s_valid === 1'b1) begin sd.push_back(s_data); si.push_back(s_idx); sl.push_back(s_last); end
            if (w_valid === 1'b1) begin wd.push_back(w_data); wl.push_back(w_last); end
            if (s_done === 1'b1) begin s_k = k; s_o = s_ovf; end
            if (w_done === 1'b1) begin w_k = k; w_o = w_ovf; end
            tick;
        end
        tests++;
        if (sd.size() != 14 || s_k != 15) begin
            fails++; $display("FAIL stop_count: got %0d terms done at %0d expected 14 done at 15", sd.size(), s_k);
        end
        if (sd.size() == 14) begin
            tests++;
            if (sd[13] !== 8'd233 || si[13] !== 6'd13 || sl[13] !== 1'b1 || sl[12] !== 1'b0) begin
                fails++; $display("FAIL stop_last: got data=%0d idx=%0d last=%b expected 233 13 1", sd[13], si[13], sl[13]);
            end
        end
        tests++;
        if (s_o !== 1'b1) begin
            fails++; $display("FAIL stop_ovf: got %b expected 1", s_o);
        end
        tests++;
        if (wd.size() != 20 || w_k != 21) begin
            fails++; $display("FAIL wrap_count: got %0d terms done at %0d expected 20 done at 21", wd.size(), w_k);
        end
        if (wd.size() == 20) begin
            tests++;
            if (wd[13] !== 8'd233 || wd[14] !== 8'd121 || wd[15] !== 8'd98 || wd[19] !== 8'd85) begin
                fails++; $display("FAIL wrap_terms: got %0d %0d %0d %0d expected 233 121 98 85", wd[13], wd[14], wd[15], wd[19]);
            end
            tests++;
            if (wl[19] !== 1'b1 || wl[13] !== 1'b0 || wl[14] !== 1'b0) begin
                fails++; $display("FAIL wrap_last: got last13=%b last14=%b last19=%b expected 0 0 1", wl[13], wl[14], wl[19]);
            end
        end
        tests++;
        if (w_o !== 1'b1 || w_ovf !== 1'b1) begin
            fails++; $display("FAIL wrap_ovf_sticky: got %b/%b expected 1/1", w_o, w_ovf);
        end
        e_num = 6'd3; e_start = 1'b1;
        tick;
        e_start = 1'b0;
        tests++;
        if (w_ovf !== 1'b0 || s_ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_clear: got wrap=%b stop=%b expected 0 0", w_ovf, s_ovf);
        end
        for (int k = 0; k < 10; k++) tick;
    endtask

    task automatic test_reset_mid;
        bit found;
        found = 0;
        a_s0 = 24'd0; a_s1 = 24'd1; a_num = 6'd20; a_start = 1'b1; a_ready = 1'b1;
        tick;
        a_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (a_valid === 1'b1 && a_idx === 6'd5) begin found = 1; break; end
            tick;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL reset_mid_reach: got no idx 5 expected idx 5 within 50 cycles");
        end
        reset = 1'b1;
        tick;
        tests++;
        if ({a_valid, a_data, a_idx, a_last, a_busy, a_done, a_ovf} !== '0) begin
            fails++; $display("FAIL reset_mid_outputs: got %h expected 0", {a_valid, a_data, a_idx, a_last, a_busy, a_done, a_ovf});
        end
        reset = 1'b0;
        a_ready = 1'b0;
        tick;
        tests++;
        if (a_done !== 1'b0 || a_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid_nodone: got done=%b valid=%b expected 0 0", a_done, a_valid);
        end
        cap24(24'd0, 24'd1, 6'd6, 1'b0, 1'b0);
        tests++;
        if (cd.size() != 6 || cd[0] !== 24'd0 || cd[5] !== 24'd5 || ci[0] !== 6'd0) begin
            fails++; $display("FAIL reset_mid_restart: got %0d terms first=%0d expected 6 terms first=0 last=5",
                              cd.size(), (cd.size() > 0) ? cd[0] : 24'hx);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_ready = 1'b0; a_num = '0; a_s0 = '0; a_s1 = '0;
        e_start = 1'b0; e_ready = 1'b0; e_num = '0; e_s0 = '0; e_s1 = '0;
        test_reset;
        test_fib35;
        test_stall;
        test_lucas;
        test_ignore_start;
        test_zero;
        test_overflow8;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
